// File: rtl/shift_deserializer_5.sv
// Serial-to-parallel converter for 5-bit words with a one-word output holding register.
// Reception continues while a finished word waits for the consumer; a word arriving with nowhere to go sets a sticky Overrun.
module shift_deserializer_5 #(
  parameter logic [4:0] BubblesMask = 5'd0,
  parameter bit         MsbFirst    = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Serial_In,
  input  logic       Serial_Valid,
  output logic [4:0] Parallel_Out,
  output logic       Out_Valid,
  input  logic       Out_Ready,
  output logic       Busy,
  output logic       Overrun
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] shift_q, shift_d;
  logic [4:0] hold_q, hold_d;
  logic       out_valid_q, out_valid_d;
  logic       overrun_q, overrun_d;
  logic       complete;

  // Both bit orders shift into the end that leaves the first bit in its final slot after five bits.
  always_comb begin
    if (MsbFirst) shift_d = Serial_Valid ? {shift_q[3:0], Serial_In} : shift_q;
    else          shift_d = Serial_Valid ? {Serial_In, shift_q[4:1]} : shift_q;
  end

  assign complete = Serial_Valid && (cnt_q == 3'd4);

  // NOTE: every variable gets a default at the top of the block so that no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (Serial_Valid) begin
      if (complete) begin
        cnt_d   = 3'd0;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + 3'd1;
        state_d = COLLECT;
      end
    end

    if (complete) begin
      if (!out_valid_q || Out_Ready) begin
        hold_d      = shift_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && Out_Ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 5'd0;
      hold_q      <= 5'd0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign Parallel_Out = hold_q ^ BubblesMask[4:0];
  assign Out_Valid    = out_valid_q;
  assign Busy         = (state_q == COLLECT);
  assign Overrun      = overrun_q;

endmodule

// File: tb/tb_shift_deserializer_5.sv
// Self-checking bench for shift_deserializer_5: one instance with default parameters (LSB first, no bubbles)
// and one with MsbFirst=1, BubblesMask=5'b10001, both driven by the same serial stream.
module tb_shift_deserializer_5;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Serial_In;
  logic       Serial_Valid;
  logic       Out_Ready;
  logic [4:0] pout_a, pout_b;
  logic       ovalid_a, ovalid_b;
  logic       busy_a, busy_b;
  logic       orun_a, orun_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  shift_deserializer_5 dut_a (
    .Clock(Clock), .Reset(Reset), .Serial_In(Serial_In), .Serial_Valid(Serial_Valid),
    .Parallel_Out(pout_a), .Out_Valid(ovalid_a), .Out_Ready(Out_Ready),
    .Busy(busy_a), .Overrun(orun_a)
  );

  shift_deserializer_5 #(.BubblesMask(5'b10001), .MsbFirst(1'b1)) dut_b (
    .Clock(Clock), .Reset(Reset), .Serial_In(Serial_In), .Serial_Valid(Serial_Valid),
    .Parallel_Out(pout_b), .Out_Valid(ovalid_b), .Out_Ready(Out_Ready),
    .Busy(busy_b), .Overrun(orun_b)
  );

  // seq[k] is the k-th bit put on the wire; exp_a/exp_b are the words each instance must present.
  typedef struct {
    logic [4:0] seq;
    int         gap;
    logic [4:0] exp_a;
    logic [4:0] exp_b;
  } vec_t;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
  } word_t;

  word_t sb_q[$];
  vec_t  vecs[5];

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_flag(input string name, input logic act, input logic exp);
    check(name, {4'b0, act}, {4'b0, exp});
  endtask

  task automatic check_status(input string tag, input logic busy, input logic ovalid, input logic orun);
    check_flag({tag, " busy_a"},    busy_a,   busy);
    check_flag({tag, " busy_b"},    busy_b,   busy);
    check_flag({tag, " ovalid_a"},  ovalid_a, ovalid);
    check_flag({tag, " ovalid_b"},  ovalid_b, ovalid);
    check_flag({tag, " overrun_a"}, orun_a,   orun);
    check_flag({tag, " overrun_b"}, orun_b,   orun);
  endtask

  // Compares the presented word against the oldest expected word once Out_Valid is up.
  task automatic pop_and_compare(input string tag);
    word_t w;
    n_checks++;
    if (!ovalid_a || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s pop: out_valid=%b, queued=%0d, required out_valid=1 and a queued word", tag, ovalid_a, sb_q.size());
    end else begin
      w = sb_q.pop_front();
      check({tag, " word_a"}, pout_a, w.a);
      check({tag, " word_b"}, pout_b, w.b);
    end
  endtask

  task automatic tick(input logic sin, input logic sval, input logic rdy);
    Serial_In    = sin;
    Serial_Valid = sval;
    Out_Ready    = rdy;
    @(posedge Clock);
    #1;
    Serial_Valid = 1'b0;
    Out_Ready    = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    Reset = 1'b0;
    sb_q.delete();
  endtask

  // Sends five bits with gap idle cycles between them; Busy and Out_Valid are checked while the word is partial.
  task automatic send_word(input string tag, input logic [4:0] seq, input int gap,
                           input logic rdy_last, input logic exp_ov);
    for (int k = 0; k < 5; k++) begin
      tick(seq[k], 1'b1, (k == 4) ? rdy_last : 1'b0);
      if (k < 4) begin
        check_flag({tag, " busy_a mid"}, busy_a, 1'b1);
        check_flag({tag, " busy_b mid"}, busy_b, 1'b1);
        check_flag({tag, " ovalid mid"}, ovalid_a, exp_ov);
        for (int g = 0; g < gap; g++) begin
          tick(1'b0, 1'b0, 1'b0);
          check_flag({tag, " busy gap"},   busy_a,   1'b1);
          check_flag({tag, " ovalid gap"}, ovalid_a, exp_ov);
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{seq: 5'b01101, gap: 0, exp_a: 5'b01101, exp_b: 5'b00111};
    vecs[1] = '{seq: 5'b01101, gap: 3, exp_a: 5'b01101, exp_b: 5'b00111};
    vecs[2] = '{seq: 5'b11111, gap: 0, exp_a: 5'b11111, exp_b: 5'b01110};
    vecs[3] = '{seq: 5'b10000, gap: 1, exp_a: 5'b10000, exp_b: 5'b10000};
    vecs[4] = '{seq: 5'b00011, gap: 2, exp_a: 5'b00011, exp_b: 5'b01001};

    Reset        = 1'b0;
    Serial_In    = 1'b0;
    Serial_Valid = 1'b0;
    Out_Ready    = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    do_reset();
    check("reset word_a", pout_a, 5'b00000);
    check("reset word_b", pout_b, 5'b10001);
    check_status("reset", 1'b0, 1'b0, 1'b0);

    // Table: each word completes, is checked, then consumed with one Out_Ready edge.
    foreach (vecs[i]) begin
      sb_q.push_back('{a: vecs[i].exp_a, b: vecs[i].exp_b});
      send_word($sformatf("vec%0d", i), vecs[i].seq, vecs[i].gap, 1'b0, 1'b0);
      check_status($sformatf("vec%0d done", i), 1'b0, 1'b1, 1'b0);
      pop_and_compare($sformatf("vec%0d", i));
      tick(1'b0, 1'b0, 1'b1);
      check_status($sformatf("vec%0d consumed", i), 1'b0, 1'b0, 1'b0);
    end

    // Out_Ready with nothing held changes nothing.
    tick(1'b0, 1'b0, 1'b1);
    check_status("ready idle", 1'b0, 1'b0, 1'b0);

    // Overrun: A held, B completes with no consumer.
    sb_q.push_back('{a: 5'b00011, b: 5'b01001});
    send_word("ovr A", 5'b00011, 0, 1'b0, 1'b0);
    pop_and_compare("ovr A");
    send_word("ovr B", 5'b11100, 0, 1'b0, 1'b1);
    check("ovr held_a", pout_a, 5'b00011);
    check("ovr held_b", pout_b, 5'b01001);
    check_status("ovr after B", 1'b0, 1'b1, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    check("ovr stable_a", pout_a, 5'b00011);
    tick(1'b0, 1'b0, 1'b1);
    check_status("ovr consumed", 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check_status("ovr sticky", 1'b0, 1'b0, 1'b1);
    do_reset();
    check_status("ovr reset", 1'b0, 1'b0, 1'b0);

    // Consume of A on the same edge that completes B.
    sb_q.push_back('{a: 5'b00011, b: 5'b01001});
    send_word("sim A", 5'b00011, 0, 1'b0, 1'b0);
    pop_and_compare("sim A");
    sb_q.push_back('{a: 5'b11100, b: 5'b10110});
    send_word("sim B", 5'b11100, 0, 1'b1, 1'b1);
    check_status("sim after B", 1'b0, 1'b1, 1'b0);
    pop_and_compare("sim B");
    tick(1'b0, 1'b0, 1'b1);
    check_status("sim consumed", 1'b0, 1'b0, 1'b0);

    // Reset mid-word discards the partial bits; the next bit is bit 0.
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 1'b0);
    check_flag("mid partial busy", busy_a, 1'b1);
    do_reset();
    check_status("mid reset", 1'b0, 1'b0, 1'b0);
    check("mid reset word_b", pout_b, 5'b10001);
    sb_q.push_back('{a: 5'b01010, b: 5'b11011});
    send_word("mid word", 5'b01010, 0, 1'b0, 1'b0);
    check_status("mid done", 1'b0, 1'b1, 1'b0);
    pop_and_compare("mid word");

    check("scoreboard empty", 5'(sb_q.size()), 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_deserializer_5.md
SHIFT_DESERIALIZER_5 -- requirements
Module: shift_deserializer_5

Interface
REQ-001 The block SHALL have parameter BubblesMask, default 0: 5-bit mask, bit i set inverts Parallel_Out[i].
REQ-002 The block SHALL have parameter MsbFirst, default 0: 0 = first received bit lands in bit 0, 1 = first received bit lands in bit 4.
REQ-003 The block SHALL have port Clock  input  1  single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port Serial_In  input  1  serial data bit.
REQ-006 The block SHALL have port Serial_Valid  input  1  Serial_In is sampled on this edge.
REQ-007 The block SHALL have port Parallel_Out  output  5  assembled word with BubblesMask applied.
REQ-008 The block SHALL have port Out_Valid  output  1  Parallel_Out holds an unconsumed word.
REQ-009 The block SHALL have port Out_Ready  input  1  consumer accepts the word on this edge.
REQ-010 The block SHALL have port Busy  output  1  a partial word (1-4 bits) is held.
REQ-011 The block SHALL have port Overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 The state machine SHALL have two states: IDLE (bit count 0) and COLLECT (bit count 1-4); Busy = 1 exactly in COLLECT.
REQ-013 Each edge with Serial_Valid=1 SHALL shift Serial_In into the shift register and increment the 3-bit bit count; edges with Serial_Valid=0 SHALL leave the count and register unchanged, with no timeout.
REQ-014 IDLE SHALL go to COLLECT on an accepted bit; COLLECT SHALL stay in COLLECT while count < 4 after the edge.
REQ-015 On the edge accepting the 5th bit, the count SHALL wrap to 0, the state SHALL return to IDLE, and the word SHALL complete.
REQ-016 With MsbFirst=0, bit k received (k=0..4) SHALL occupy word bit k; with MsbFirst=1 it SHALL occupy word bit 4-k.
REQ-017 Parallel_Out SHALL equal the output holding register XOR BubblesMask[4:0], with no arithmetic and no width extension.
REQ-018 Word completion latency: Out_Valid and the new Parallel_Out SHALL be visible in the cycle after the edge accepting the 5th bit.
REQ-019 The shift register and the output holding register SHALL be separate, so serial reception continues while Out_Valid=1.
REQ-020 Handshake: on an edge with Out_Valid=1 and Out_Ready=1 and no completion, Out_Valid SHALL clear to 0.
REQ-021 Out_Valid=1 SHALL hold Parallel_Out stable until consumed.
REQ-022 Out_Ready while Out_Valid=0 SHALL have no effect.
REQ-023 Completion with Out_Valid=0 SHALL load the holding register and set Out_Valid.
REQ-024 Completion with Out_Valid=1 and Out_Ready=1 on the same edge SHALL load the new word and keep Out_Valid=1, with no overrun.
REQ-025 Completion with Out_Valid=1 and Out_Ready=0 SHALL discard the new word, keep the old word and Out_Valid=1, and set Overrun.
REQ-026 Overrun, once set, SHALL remain 1 until Reset.

Reset
REQ-027 Reset=1 at an edge SHALL force IDLE, bit count 0, shift register 0, holding register 0, Out_Valid 0, Busy 0, and Overrun 0, overriding all other inputs on that edge.
REQ-028 Parallel_Out after reset SHALL read BubblesMask[4:0].
REQ-029 Reset asserted mid-word SHALL discard the partial word, and the next accepted bit SHALL be treated as bit 0.

Verification
REQ-030 Bench SHALL cover basic framing: MsbFirst=0, BubblesMask=0, bits 1,0,1,1,0 on consecutive edges, Out_Ready=0 -> Busy=1 after bits 1-4; after 5th edge Parallel_Out=5'b01101, Out_Valid=1, Busy=0.
REQ-031 Bench SHALL cover bubbles and bit order: BubblesMask=5'b10001, MsbFirst=1, bits 1,0,1,1,0 -> Parallel_Out=5'b00111.
REQ-032 Bench SHALL cover gapped input: same 5 bits with Serial_Valid=0 for 3 cycles between each -> same word as the gapless case, and Out_Valid rises only after the 5th valid bit.
REQ-033 Bench SHALL cover overrun: word A=5'b00011 held with Out_Ready=0, then word B=5'b11100 completes -> Parallel_Out stays 5'b00011 and Overrun=1; after Out_Ready=1 for one edge, Out_Valid=0 and Overrun still 1.
REQ-034 Bench SHALL cover simultaneous consume and complete: Out_Valid=1 with word A, Out_Ready=1 on the edge of B's 5th bit -> Parallel_Out=B, Out_Valid=1, Overrun=0.
REQ-035 Bench SHALL cover reset mid-word: 3 bits accepted, Reset=1 for one edge, then bits 0,1,0,1,0 -> Busy=0 after reset and Parallel_Out=5'b01010 with MsbFirst=0, BubblesMask=0.
